// File: rtl/shift_defs.sv
// rtl/shift_defs.sv - shared mode and burst-state encodings for the universal shift register
package shift_defs;

    // Manual operation selected by the mode port while idle
    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_LOAD   = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_e;

    // Burst controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BURST = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Direction encoding: right moves toward bit 0, left toward the MSB
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/usr_burst_ctrl.sv
// rtl/usr_burst_ctrl.sv - burst sequencing FSM and bit counter for the universal shift register
module usr_burst_ctrl
    import shift_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic start,
    input  logic dir,
    output logic burst_dir,
    output logic busy,
    output logic done,
    output logic idle,
    output logic load_burst,
    output logic burst_step
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          burst_dir_q, burst_dir_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // Next-state logic: launch on start in IDLE, one shift per enabled BURST cycle, single DONE cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_dir_d = burst_dir_q;
        load_burst  = 1'b0;
        burst_step  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_burst  = 1'b1;
                    burst_dir_d = dir;
                    cnt_d       = '0;
                    state_d     = ST_BURST;
                end
            end
            ST_BURST: begin
                if (en) begin
                    burst_step = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        // Counter is parked at zero so it never passes WIDTH-1
                        cnt_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately ignored here; a new burst must begin from IDLE
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_BURST);
        done_d = (state_d == ST_DONE);
    end

    // Single state register with synchronous reset; busy/done registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            burst_dir_q <= DIR_RIGHT;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            burst_dir_q <= burst_dir_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign burst_dir = burst_dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign idle      = (state_q == ST_IDLE);

endmodule

// File: rtl/nbit_universal_shift_reg.sv
// rtl/nbit_universal_shift_reg.sv - N-bit universal shift register with hold/shift/load/rotate and serialising burst
module nbit_universal_shift_reg
    import shift_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [WIDTH-1:0] datain,
    input  logic             ser_in,
    input  logic             start,
    output logic [WIDTH-1:0] dataout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             burst_dir;
    logic             idle;
    logic             load_burst;
    logic             burst_step;
    logic             sout_dir;

    // Move one place toward bit 0, fill enters at the MSB
    function automatic logic [WIDTH-1:0] step_right(input logic [WIDTH-1:0] v, input logic fill);
        return {fill, v[WIDTH-1:1]};
    endfunction

    // Move one place toward the MSB, fill enters at bit 0
    function automatic logic [WIDTH-1:0] step_left(input logic [WIDTH-1:0] v, input logic fill);
        return {v[WIDTH-2:0], fill};
    endfunction

    usr_burst_ctrl #(
        .WIDTH(WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .dir        (dir),
        .burst_dir  (burst_dir),
        .busy       (busy),
        .done       (done),
        .idle       (idle),
        .load_burst (load_burst),
        .burst_step (burst_step)
    );

    // Datapath mux: burst launch and burst shifts take priority over the manual mode
    always_comb begin
        data_d = data_q;
        if (load_burst) begin
            data_d = datain;
        end else if (burst_step) begin
            data_d = (burst_dir == DIR_LEFT) ? step_left(data_q, ser_in)
                                             : step_right(data_q, ser_in);
        end else if (idle && en) begin
            case (mode_e'(mode))
                MODE_HOLD:   data_d = data_q;
                MODE_SHIFT:  data_d = (dir == DIR_LEFT) ? step_left(data_q, ser_in)
                                                        : step_right(data_q, ser_in);
                MODE_LOAD:   data_d = datain;
                MODE_ROTATE: data_d = (dir == DIR_LEFT) ? step_left(data_q, data_q[WIDTH-1])
                                                        : step_right(data_q, data_q[0]);
                default:     data_d = data_q;
            endcase
        end
    end

    // Register contents with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // The serial output follows the latched burst direction while busy, the live dir otherwise
    assign sout_dir = busy ? burst_dir : dir;
    assign sout     = (sout_dir == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];
    assign dataout  = data_q;

endmodule

// File: doc/nbit_universal_shift_reg.md
NBIT_UNIVERSAL_SHIFT_REG -- requirements
Module: nbit_universal_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  clock enable for manual modes and burst progress.
REQ-005 SHALL have port mode  input  2  manual operation: 00 hold, 01 shift, 10 parallel load, 11 rotate.
REQ-006 SHALL have port dir  input  1  direction: 0 = right (toward bit 0), 1 = left (toward MSB).
REQ-007 SHALL have port datain  input  WIDTH  parallel load data.
REQ-008 SHALL have port ser_in  input  1  fill bit entering on a shift (MSB on right shift, LSB on left shift).
REQ-009 SHALL have port start  input  1  one-cycle request to launch a serialising burst.
REQ-010 SHALL have port dataout  output  WIDTH  current register contents.
REQ-011 SHALL have port sout  output  1  bit leaving in the current direction: dataout[0] if dir is right, dataout[WIDTH-1] if dir is left.
REQ-012 SHALL have port busy  output  1  high while a burst is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse after a burst completes.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BURST, DONE.
REQ-015 In IDLE with start=0 and en=1, mode SHALL act on the next edge:
  - hold: register unchanged.
  - shift: move one place in dir; ser_in fills the vacated bit.
  - load: register takes datain.
  - rotate: move one place in dir; the exiting bit wraps to the vacated end.
REQ-016 In IDLE with en=0 and start=0, the register SHALL hold.
REQ-017 In IDLE, start=1 SHALL override mode and en on that edge:
  - register loads datain;
  - dir is latched as burst_dir;
  - bit counter clears to 0;
  - FSM enters BURST.
REQ-018 In BURST with en=1, each edge SHALL perform one shift in burst_dir with ser_in fill and increment the counter.
REQ-019 In BURST, the edge on which the counter equals WIDTH-1 SHALL perform the last shift and move the FSM to DONE.
REQ-020 busy SHALL be high in exactly WIDTH enabled cycles per burst.
REQ-021 In BURST with en=0, register, counter and state SHALL hold; busy stays high.
REQ-022 In BURST, the mode, dir and start inputs SHALL be ignored; sout SHALL use burst_dir.
REQ-023 DONE SHALL last one cycle with done=1 and busy=0, register held, then return to IDLE.
REQ-024 start asserted in DONE SHALL be ignored; a new burst needs start in IDLE.
REQ-025 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL never exceed WIDTH-1.
REQ-026 Outputs dataout, busy and done SHALL be registered; sout SHALL be combinational from the register and the direction.

Reset
REQ-027 rst=1 on an edge SHALL force, regardless of state, en or start:
  - register = 0, counter = 0, burst_dir = 0;
  - FSM = IDLE, busy = 0, done = 0.
REQ-028 Reset during BURST SHALL abort the burst with no done pulse.
REQ-029 After reset, sout SHALL read 0.

Structure
REQ-030 The mode encodings (HOLD, SHIFT, LOAD, ROTATE) and FSM state encodings SHALL live in a shared header, shift_defs, used by RTL and bench.
REQ-031 The FSM plus bit counter SHALL be one sub-module, usr_burst_ctrl; the datapath shift/rotate/load mux stays in the top module.

Verification (WIDTH=4)
REQ-032 Manual load and shift: load 1001, then shift right with ser_in=0 -> dataout 0100; shift left with ser_in=1 -> 1001.
REQ-033 Rotate: load 1001, rotate left -> 0011; rotate right twice -> 1100.
REQ-034 Burst: start with datain=1011, dir=0, ser_in=0:
  - busy high for 4 cycles;
  - sout sequence 1,1,0,1;
  - done high in cycle 5;
  - final dataout 0000.
REQ-035 Burst pause: same burst with en=0 for 2 mid-burst cycles -> busy lasts 6 cycles; sout sequence and final value unchanged.
REQ-036 Reset mid-burst: rst after 2 shifts -> next cycle dataout=0000, busy=0, and no done pulse.
REQ-037 Ignored inputs: start and mode=LOAD during BURST have no effect; start in the DONE cycle does not relaunch.
